// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 draw engine: FSM states, display
// geometry defaults and sprite dimensions.
package chip8_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAddr2,
      StRow,
      StClear,
      StDone
   } draw_state_e;

   localparam int unsigned DispWDefault  = 64;
   localparam int unsigned DispHDefault  = 32;
   localparam int unsigned SchipDispW    = 128;
   localparam int unsigned SchipDispH    = 64;

   localparam int unsigned SpriteWNarrow = 8;
   localparam int unsigned SpriteWWide   = 16;
   localparam int unsigned WideRows      = 16;

   // Sprite bytes are MSB-first on screen while framebuffer bit c is column c.
   function automatic logic [15:0] bit_reverse16(input logic [15:0] v);
      logic [15:0] r;
      for (int k = 0; k < 16; k++) begin
         r[k] = v[15-k];
      end
      return r;
   endfunction

endpackage

// File: rtl/chip8_draw_engine_if.sv
// Command, sprite-memory and framebuffer signals between the CHIP-8 core and
// the draw engine.
interface chip8_draw_engine_if import chip8_pkg::*; #(
   parameter int unsigned DISP_W = DispWDefault,
   parameter int unsigned DISP_H = DispHDefault,
   parameter int unsigned ADDR_W = 12
);
   localparam int unsigned RowW = $clog2(DISP_H);

   logic              start;
   logic              clr_start;
   logic [7:0]        x_in;
   logic [7:0]        y_in;
   logic [3:0]        n_in;
   logic [ADDR_W-1:0] i_in;
   logic              clip_en;
   logic              busy;
   logic              done;
   logic              collision;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic [RowW-1:0]   fb_row;
   logic [DISP_W-1:0] fb_rdata;
   logic              fb_we;
   logic [DISP_W-1:0] fb_wdata;

   modport master (
      output start, clr_start, x_in, y_in, n_in, i_in, clip_en, mem_rdata, fb_rdata,
      input  busy, done, collision, mem_addr, fb_row, fb_we, fb_wdata
   );

   modport slave (
      input  start, clr_start, x_in, y_in, n_in, i_in, clip_en, mem_rdata, fb_rdata,
      output busy, done, collision, mem_addr, fb_row, fb_we, fb_wdata
   );

endinterface

// File: rtl/chip8_sprite_row.sv
// Combinational sprite-row placer: turns up to 16 sprite pixels into a
// framebuffer-row XOR mask, wrapping or clipping at the right edge.
module chip8_sprite_row import chip8_pkg::*; #(
   parameter int unsigned DISP_W = DispWDefault
) (
   input  logic [15:0]                spr_data,
   input  logic                       wide,
   input  logic [$clog2(DISP_W)-1:0]  x0,
   input  logic                       clip_en,
   output logic [DISP_W-1:0]          mask
);

   logic [15:0]         pix;
   logic [2*DISP_W-1:0] placed;

   // Shift into a double-width row; the upper half holds pixels past the edge.
   always_comb begin
      pix = bit_reverse16(spr_data);
      if (!wide) begin
         pix[15:8] = 8'h00;
      end
      placed = {{(2*DISP_W-16){1'b0}}, pix} << x0;
      mask   = placed[DISP_W-1:0];
      if (!clip_en) begin
         mask = mask | placed[2*DISP_W-1:DISP_W];
      end
   end

endmodule

// File: rtl/chip8_draw_engine.sv
// Multi-cycle DXYN/00E0 engine: fetches sprite bytes over a synchronous read
// port and read-modify-writes the framebuffer one row per cycle.
module chip8_draw_engine import chip8_pkg::*; #(
   parameter int unsigned DISP_W  = DispWDefault,
   parameter int unsigned DISP_H  = DispHDefault,
   parameter int unsigned ADDR_W  = 12,
   parameter bit          WIDE_EN = 1'b0
) (
   input logic                instruction_clk,
   input logic                rst,
   chip8_draw_engine_if.slave bus
);

   localparam int unsigned XW   = $clog2(DISP_W);
   localparam int unsigned YW   = $clog2(DISP_H);
   // Wide enough for row index 0..15, clear index 0..DISP_H-1 and y0+row.
   localparam int unsigned CntW = ((YW > 4) ? YW : 4) + 1;

   draw_state_e       state_q, state_d;
   logic [XW-1:0]     x0_q, x0_d;
   logic [YW-1:0]     y0_q, y0_d;
   logic [4:0]        rows_q, rows_d;
   logic              wide_q, wide_d;
   logic              clip_q, clip_d;
   logic [CntW-1:0]   row_q, row_d;
   logic [7:0]        hi_q, hi_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              collision_q, collision_d;

   logic [XW+7:0]     x_ext;
   logic [YW+7:0]     y_ext;
   logic              wide_cmd;
   logic [CntW-1:0]   y_sum;
   logic              y_off;
   logic [15:0]       spr_data;
   logic [DISP_W-1:0] mask;
   logic              busy;
   logic              done;
   logic              fb_we;
   logic [YW-1:0]     fb_row;
   logic [DISP_W-1:0] fb_wdata;

   assign x_ext    = {{XW{1'b0}}, bus.x_in};
   assign y_ext    = {{YW{1'b0}}, bus.y_in};
   assign wide_cmd = WIDE_EN && (bus.n_in == 4'd0);
   assign y_sum    = CntW'(y0_q) + row_q;
   assign y_off    = (y_sum >= CntW'(DISP_H));
   assign spr_data = wide_q ? {hi_q, bus.mem_rdata} : {bus.mem_rdata, 8'h00};

   chip8_sprite_row #(
      .DISP_W (DISP_W)
   ) u_sprite_row (
      .spr_data (spr_data),
      .wide     (wide_q),
      .x0       (x0_q),
      .clip_en  (clip_q),
      .mask     (mask)
   );

   always_comb begin
      state_d     = state_q;
      x0_d        = x0_q;
      y0_d        = y0_q;
      rows_d      = rows_q;
      wide_d      = wide_q;
      clip_d      = clip_q;
      row_d       = row_q;
      hi_d        = hi_q;
      mem_addr_d  = mem_addr_q;
      collision_d = collision_q;
      busy        = 1'b0;
      done        = 1'b0;
      fb_we       = 1'b0;
      fb_row      = '0;
      fb_wdata    = '0;

      unique case (state_q)
         StIdle: begin
            if (bus.clr_start) begin
               state_d     = StClear;
               row_d       = '0;
               collision_d = 1'b0;
            end else if (bus.start) begin
               x0_d        = x_ext[XW-1:0];
               y0_d        = y_ext[YW-1:0];
               wide_d      = wide_cmd;
               clip_d      = bus.clip_en;
               rows_d      = wide_cmd ? 5'(WideRows) : {1'b0, bus.n_in};
               row_d       = '0;
               mem_addr_d  = bus.i_in;
               collision_d = 1'b0;
               state_d     = (bus.n_in == 4'd0 && !WIDE_EN) ? StDone : StAddr;
            end
         end

         StAddr: begin
            busy       = 1'b1;
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            state_d    = wide_q ? StAddr2 : StRow;
         end

         StAddr2: begin
            busy       = 1'b1;
            hi_d       = bus.mem_rdata;
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            state_d    = StRow;
         end

         StRow: begin
            busy     = 1'b1;
            fb_row   = y_sum[YW-1:0];
            fb_wdata = bus.fb_rdata ^ mask;
            // Clipped rows still take their cycles but never write or collide.
            fb_we    = !(clip_q && y_off);
            if (fb_we && ((bus.fb_rdata & mask) != '0)) begin
               collision_d = 1'b1;
            end
            if (row_q == CntW'(rows_q) - CntW'(1)) begin
               state_d = StDone;
            end else begin
               row_d   = row_q + CntW'(1);
               state_d = StAddr;
            end
         end

         StClear: begin
            busy   = 1'b1;
            fb_row = row_q[YW-1:0];
            fb_we  = 1'b1;
            if (row_q == CntW'(DISP_H - 1)) begin
               state_d = StDone;
            end else begin
               row_d = row_q + CntW'(1);
            end
         end

         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge instruction_clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         x0_q        <= '0;
         y0_q        <= '0;
         rows_q      <= '0;
         wide_q      <= 1'b0;
         clip_q      <= 1'b0;
         row_q       <= '0;
         hi_q        <= '0;
         mem_addr_q  <= '0;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x0_q        <= x0_d;
         y0_q        <= y0_d;
         rows_q      <= rows_d;
         wide_q      <= wide_d;
         clip_q      <= clip_d;
         row_q       <= row_d;
         hi_q        <= hi_d;
         mem_addr_q  <= mem_addr_d;
         collision_q <= collision_d;
      end
   end

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.collision = collision_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.fb_row    = fb_row;
   assign bus.fb_we     = fb_we;
   assign bus.fb_wdata  = fb_wdata;

endmodule

// File: tb/tb_chip8_draw_engine.sv
// Bench for chip8_draw_engine: a 64x32 narrow instance and a 128x64 wide one,
// checked against a pixel-level reference model.
module tb_chip8_draw_engine;

   logic instruction_clk;
   logic rst;

   int   n_chk;
   int   n_err;

   logic [7:0]   mem  [4096];
   logic [63:0]  fb_a [32];
   logic [127:0] fb_b [64];
   bit   [63:0]  mdl  [32];

   chip8_draw_engine_if #(.DISP_W(64),  .DISP_H(32), .ADDR_W(12)) ia ();
   chip8_draw_engine_if #(.DISP_W(128), .DISP_H(64), .ADDR_W(12)) ib ();

   chip8_draw_engine #(
      .DISP_W  (64),
      .DISP_H  (32),
      .ADDR_W  (12),
      .WIDE_EN (1'b0)
   ) u_dut_a (
      .instruction_clk (instruction_clk),
      .rst             (rst),
      .bus             (ia)
   );

   chip8_draw_engine #(
      .DISP_W  (128),
      .DISP_H  (64),
      .ADDR_W  (12),
      .WIDE_EN (1'b1)
   ) u_dut_b (
      .instruction_clk (instruction_clk),
      .rst             (rst),
      .bus             (ib)
   );

   initial instruction_clk = 1'b0;
   always #5 instruction_clk = ~instruction_clk;

   always @(posedge instruction_clk) begin
      ia.mem_rdata <= mem[ia.mem_addr];
      ib.mem_rdata <= mem[ib.mem_addr];
      if (ia.fb_we) fb_a[ia.fb_row] <= ia.fb_wdata;
      if (ib.fb_we) fb_b[ib.fb_row] <= ib.fb_wdata;
   end

   assign ia.fb_rdata = fb_a[ia.fb_row];
   assign ib.fb_rdata = fb_b[ib.fb_row];

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference: walk every sprite pixel and toggle it in a plain bit array.
   task automatic model_draw(input int x, input int y, input int n, input int i,
                             input bit clip, output bit coll, output int rows_on);
      coll    = 1'b0;
      rows_on = 0;
      for (int r = 0; r < n; r++) begin
         int yy;
         logic [7:0] b;
         yy = (y % 32) + r;
         if (yy >= 32) begin
            if (clip) continue;
            yy -= 32;
         end
         rows_on++;
         b = mem[(i + r) % 4096];
         for (int k = 0; k < 8; k++) begin
            int col;
            if (!b[7-k]) continue;
            col = (x % 64) + k;
            if (col >= 64) begin
               if (clip) continue;
               col -= 64;
            end
            if (mdl[yy][col]) coll = 1'b1;
            mdl[yy][col] = ~mdl[yy][col];
         end
      end
   endtask

   task automatic check_fb_a(input string tag);
      for (int r = 0; r < 32; r++) begin
         check($sformatf("%s_row%0d", tag, r), 128'(fb_a[r]), 128'(mdl[r]));
      end
   endtask

   task automatic issue(input bit sel, input bit clr, input logic [7:0] x, input logic [7:0] y,
                        input logic [3:0] n, input logic [11:0] i, input bit clip);
      @(negedge instruction_clk);
      if (sel) begin
         ib.x_in = x; ib.y_in = y; ib.n_in = n; ib.i_in = i; ib.clip_en = clip;
         if (clr) ib.clr_start = 1'b1; else ib.start = 1'b1;
      end else begin
         ia.x_in = x; ia.y_in = y; ia.n_in = n; ia.i_in = i; ia.clip_en = clip;
         if (clr) ia.clr_start = 1'b1; else ia.start = 1'b1;
      end
      @(posedge instruction_clk);
      #1;
      ia.start = 1'b0; ia.clr_start = 1'b0;
      ib.start = 1'b0; ib.clr_start = 1'b0;
   endtask

   // Counts cycles from the accept edge to done; poke drives a stray start mid-command.
   task automatic wait_done(input bit sel, input bit poke, output int cyc, output int we_cnt,
                            output bit busy_ok);
      bit seen;
      seen    = 1'b0;
      cyc     = 0;
      we_cnt  = 0;
      busy_ok = 1'b1;
      for (int t = 0; t < 400 && !seen; t++) begin
         @(negedge instruction_clk);
         cyc++;
         if (poke && cyc == 5) begin
            if (sel) ib.start = 1'b1; else ia.start = 1'b1;
         end
         if (poke && cyc == 6) begin
            ia.start = 1'b0; ib.start = 1'b0;
         end
         if (sel ? ib.done : ia.done) begin
            seen = 1'b1;
            if (sel ? ib.busy : ia.busy) busy_ok = 1'b0;
         end else begin
            if (!(sel ? ib.busy : ia.busy)) busy_ok = 1'b0;
            if (sel ? ib.fb_we : ia.fb_we) we_cnt++;
         end
      end
      if (!seen) cyc = -1;
   endtask

   task automatic clear_fb(input bit sel, input string tag);
      int cyc, we_cnt;
      bit busy_ok;
      logic [127:0] any;
      issue(sel, 1'b1, 8'd0, 8'd0, 4'd0, 12'd0, 1'b0);
      wait_done(sel, 1'b1, cyc, we_cnt, busy_ok);
      check({tag, "_done_cyc"}, 128'(cyc), sel ? 128'd65 : 128'd33);
      check({tag, "_writes"}, 128'(we_cnt), sel ? 128'd64 : 128'd32);
      check({tag, "_busy"}, 128'(busy_ok), 128'd1);
      check({tag, "_coll"}, 128'(sel ? ib.collision : ia.collision), 128'd0);
      @(negedge instruction_clk);
      check({tag, "_idle_after"}, 128'(sel ? ib.busy : ia.busy), 128'd0);
      any = '0;
      if (sel) begin
         for (int r = 0; r < 64; r++) any |= fb_b[r];
      end else begin
         for (int r = 0; r < 32; r++) begin
            any |= 128'(fb_a[r]);
            mdl[r] = '0;
         end
      end
      check({tag, "_blank"}, any, 128'd0);
   endtask

   task automatic draw_a(input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                         input logic [11:0] i, input bit clip, input string tag);
      bit   coll, busy_ok;
      int   rows_on, cyc, we_cnt, exp_cyc;
      model_draw(int'(x), int'(y), int'(n), int'(i), clip, coll, rows_on);
      exp_cyc = (n == 4'd0) ? 1 : 2 * int'(n) + 1;
      issue(1'b0, 1'b0, x, y, n, i, clip);
      wait_done(1'b0, 1'b0, cyc, we_cnt, busy_ok);
      check({tag, "_done_cyc"}, 128'(cyc), 128'(exp_cyc));
      check({tag, "_coll"}, 128'(ia.collision), 128'(coll));
      check({tag, "_writes"}, 128'(we_cnt), 128'(rows_on));
      check({tag, "_busy"}, 128'(busy_ok), 128'd1);
      check_fb_a(tag);
   endtask

   initial begin
      int   cyc, we_cnt;
      bit   busy_ok;
      logic [127:0] wide_row;

      n_chk = 0;
      n_err = 0;
      rst   = 1'b1;
      ia.start = 1'b0; ia.clr_start = 1'b0; ia.x_in = '0; ia.y_in = '0;
      ia.n_in  = '0;   ia.i_in = '0;        ia.clip_en = 1'b0;
      ib.start = 1'b0; ib.clr_start = 1'b0; ib.x_in = '0; ib.y_in = '0;
      ib.n_in  = '0;   ib.i_in = '0;        ib.clip_en = 1'b0;
      for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);

      repeat (2) @(negedge instruction_clk);
      check("rst_busy", 128'(ia.busy), 128'd0);
      check("rst_done", 128'(ia.done), 128'd0);
      check("rst_coll", 128'(ia.collision), 128'd0);
      check("rst_we", 128'(ia.fb_we), 128'd0);
      check("rst_addr", 128'(ia.mem_addr), 128'd0);
      check("rst_b_busy", 128'(ib.busy | ib.fb_we | ib.done), 128'd0);
      rst = 1'b0;

      clear_fb(1'b0, "clr_a");
      clear_fb(1'b1, "clr_b");

      // Font glyph "0"
      mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
      mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
      draw_a(8'd0, 8'd0, 4'd5, 12'h050, 1'b0, "font");
      check("font_r0", 128'(fb_a[0][3:0]), 128'hF);
      check("font_r1", 128'(fb_a[1][3:0]), 128'h9);
      check("font_r4", 128'(fb_a[4][3:0]), 128'hF);
      check("font_coll0", 128'(ia.collision), 128'd0);
      draw_a(8'd0, 8'd0, 4'd5, 12'h050, 1'b0, "redraw");
      check("redraw_coll1", 128'(ia.collision), 128'd1);

      mem[12'h100] = 8'hFF; mem[12'h101] = 8'h81;
      draw_a(8'd62, 8'd31, 4'd2, 12'h100, 1'b0, "wrap");
      check("wrap_r31", 128'(fb_a[31]), 128'h0000_0000_0000_0000_C000_0000_0000_003F);
      check("wrap_r0", 128'(fb_a[0]), 128'h0000_0000_0000_0000_4000_0000_0000_0020);
      clear_fb(1'b0, "clr_a2");
      draw_a(8'd62, 8'd31, 4'd2, 12'h100, 1'b1, "clip");
      check("clip_r31", 128'(fb_a[31]), 128'h0000_0000_0000_0000_C000_0000_0000_0000);
      check("clip_r0", 128'(fb_a[0]), 128'd0);

      // Overlap only in the first row of a three-row sprite
      clear_fb(1'b0, "clr_a3");
      mem[12'h200] = 8'h80; mem[12'h201] = 8'h01; mem[12'h202] = 8'h01;
      draw_a(8'd10, 8'd5, 4'd1, 12'h200, 1'b0, "pre");
      draw_a(8'd10, 8'd5, 4'd3, 12'h200, 1'b0, "first_row");
      check("first_row_coll", 128'(ia.collision), 128'd1);

      for (int t = 0; t < 20; t++) begin
         draw_a(8'($urandom), 8'($urandom), 4'($urandom), 12'($urandom), 1'($urandom),
                $sformatf("rnd%0d", t));
      end
      draw_a(8'd7, 8'd9, 4'd0, 12'h123, 1'b0, "zero_rows");

      // Wide 16x16 sprite wrapping off the right edge of the 128x64 display
      for (int a = 0; a < 32; a++) mem[12'h300 + a] = 8'hFF;
      issue(1'b1, 1'b0, 8'd120, 8'd3, 4'd0, 12'h300, 1'b0);
      wait_done(1'b1, 1'b0, cyc, we_cnt, busy_ok);
      check("wide_done_cyc", 128'(cyc), 128'd49);
      check("wide_writes", 128'(we_cnt), 128'd16);
      check("wide_busy", 128'(busy_ok), 128'd1);
      check("wide_coll", 128'(ib.collision), 128'd0);
      for (int r = 0; r < 64; r++) begin
         wide_row = (r >= 3 && r < 19) ? 128'hFF00_0000_0000_0000_0000_0000_0000_00FF : '0;
         check($sformatf("wide_row%0d", r), fb_b[r], wide_row);
      end

      // Asynchronous reset in the middle of a row write
      issue(1'b0, 1'b0, 8'd3, 8'd4, 4'd15, 12'h050, 1'b0);
      repeat (4) @(negedge instruction_clk);
      check("mid_we_before", 128'(ia.fb_we), 128'd1);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_busy", 128'(ia.busy), 128'd0);
      check("mid_rst_we", 128'(ia.fb_we), 128'd0);
      check("mid_rst_done", 128'(ia.done), 128'd0);
      @(negedge instruction_clk);
      rst = 1'b0;
      @(negedge instruction_clk);
      check("mid_rst_idle", 128'(ia.busy), 128'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
